multi_bank_arbiter: RTL
=======================

Name: multi_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-ported multi-bank memory among NUM_REQ requesters.
- Each requester has a valid/ready request channel and a response channel.
- The memory side drives the multi-bank memory's clk/we/addr/din/bank_sel/dout port, which has a registered read.
- The arbiter issues registered commands, tracks in-flight ownership, and routes read data and write acks back to the issuing requester.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, per-bank address width.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- req_we  in  NUM_REQ  1=write, 0=read, per requester.
- req_bank  in  2*NUM_REQ  bank select, requester i at [2i+1:2i].
- req_addr  in  ADDR_WIDTH*NUM_REQ  word address, packed likewise.
- req_wdata  in  DATA_WIDTH*NUM_REQ  write data, packed likewise.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters; meaningful when rsp_valid is set for a read.
- mem_we  out  1  to memory we.
- mem_bank_sel  out  2  to memory bank_sel.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_din  out  DATA_WIDTH  to memory din.
- mem_dout  in  DATA_WIDTH  from memory dout (registered, 1-cycle read).

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0.
  - mem_we=0; mem_bank_sel, mem_addr, mem_din = 0.
  - rsp_valid=0, rsp_data=0.
  - Both in-flight tag stages invalid.
  - Reset asserted mid-operation discards in-flight requests; no response is ever emitted for them.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit receives req_ready; all other ready bits are 0.
  - No valid request → req_ready=0.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: on acceptance of requester g, rr_ptr <= (g+1) mod NUM_REQ. No acceptance → rr_ptr holds.
- Throughput: one request per cycle sustained, no bubbles.
- Command stage (cycle T = acceptance):
  - At the T edge, register mem_we=req_we[g], plus the bank, addr and wdata of requester g.
  - Register tag stage 1 = {valid=1, id=g, is_write}.
  - No acceptance → mem_we<=0; bank/addr/din hold their previous values.
- Memory stage: the memory captures the command at the end of T+1; mem_dout is valid in T+2.
- Response stage:
  - Tag stage 2 <= tag stage 1.
  - In T+2: rsp_valid[id]=1 for exactly one cycle.
  - Reads: rsp_data=mem_dout. Writes: rsp_data is don't-care (ack only).
- Latency: fixed at 2 cycles from acceptance to rsp_valid, for reads and writes alike. Responses return in acceptance order.
- Ordering and hazards:
  - Write accepted at T followed by a read of the same bank/address accepted at T+1 → the read returns the new data.
  - Read and write are never issued in the same cycle, so there is no same-cycle hazard.
- Requesters must always accept responses; there is no rsp backpressure.
- Out-of-range bank values cannot occur, because 2 bits address exactly 4 banks.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input req_lock (NUM_REQ).
  - An accepted beat with req_lock[g]=1 makes g the lock owner. From the next cycle, req_ready is given only to g; other requesters are stalled.
  - The lock is released after an accepted beat with req_lock[g]=0, or in any cycle where req_valid[g]=0.
  - On release, normal round-robin resumes from (g+1) mod NUM_REQ.
  - Reset clears the lock.
- Undefined: the req_lock port is absent; pure round-robin.

Test Plan:
- Reset → mem_we=0, rsp_valid=0, req_ready=0; assert rst mid-stream with 2 reads in flight → no rsp_valid after deassert.
- Req0 writes 0xA5 to bank2/addr5, then req1 reads bank2/addr5 → rsp_valid[1] 2 cycles after acceptance, rsp_data=0xA5.
- All 4 requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; rsp_valid follows the same order with 2-cycle lag.
- Back-to-back: write 0x3C to bank1/addr15 at T, read the same location at T+1 → read returns 0x3C; the write ack (rsp_valid at T+2) precedes the read response (T+3).
- Only req3 valid with rr_ptr=3, then req0 and req2 valid → req3 granted, pointer wraps, then req0 is granted before req2.
- ARB_LOCK_EN: req1 issues 3 beats with lock=1,1,0 while req0/req2 are valid → req1 is granted 3 consecutive cycles, then req2 is granted.

Source files
------------

// File: rtl/multi_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-read multi-bank memory among NUM_REQ requesters.
// Latency: command registered at the acceptance edge; rsp_valid strobes 2 cycles after acceptance, in order.
// Backpressure: one-hot req_ready per cycle, none on responses. Optional macro ARB_LOCK_EN adds req_lock.
module multi_bank_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REQ    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [2*NUM_REQ-1:0]          req_bank,
   input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
`ifdef ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          mem_we,
   output logic [1:0]                    mem_bank_sel,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // In-flight ownership record, one per pipeline stage between command and response.
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic            is_write;
   } tag_t;

   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                  mem_we_q, mem_we_d;
   logic [1:0]            mem_bank_sel_q, mem_bank_sel_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   tag_t                  tag1_q, tag1_d;
   tag_t                  tag2_q, tag2_d;

   logic                  grant_vld;
   logic [ID_W-1:0]       grant_id;

`ifdef ARB_LOCK_EN
   logic                  lock_vld_q, lock_vld_d;
   logic [ID_W-1:0]       lock_id_q, lock_id_d;
`endif

   // (base + off) mod NUM_REQ, with off always below NUM_REQ
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Grant selection: first valid requester at or after rr_ptr; a live lock owner overrides.
   always_comb begin
      logic [ID_W-1:0] cand;
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      // Walk from the farthest offset down so the nearest valid requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = wrap_idx(rr_ptr_q, k);
         if (req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_id  = cand;
         end
      end
`ifdef ARB_LOCK_EN
      // An owner that drops valid loses the lock this cycle, so round-robin applies instead.
      if (lock_vld_q && req_valid[lock_id_q]) begin
         grant_vld = 1'b1;
         grant_id  = lock_id_q;
      end
`endif
      req_ready = '0;
      if (grant_vld) req_ready[grant_id] = 1'b1;
   end

   // Next-state for pointer, command register, tag pipeline and lock.
   always_comb begin
      int gi;
      gi             = int'(grant_id);
      rr_ptr_d       = grant_vld ? wrap_idx(grant_id, 1) : rr_ptr_q;
      mem_we_d       = grant_vld & req_we[grant_id];
      mem_bank_sel_d = mem_bank_sel_q;
      mem_addr_d     = mem_addr_q;
      mem_din_d      = mem_din_q;
      if (grant_vld) begin
         mem_bank_sel_d = req_bank[2*gi +: 2];
         mem_addr_d     = req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH];
         mem_din_d      = req_wdata[DATA_WIDTH*gi +: DATA_WIDTH];
      end
      tag1_d.vld      = grant_vld;
      tag1_d.id       = grant_id;
      tag1_d.is_write = req_we[grant_id];
      tag2_d          = tag1_q;
`ifdef ARB_LOCK_EN
      lock_vld_d = lock_vld_q;
      lock_id_d  = lock_id_q;
      if (grant_vld) begin
         lock_vld_d = req_lock[grant_id];
         lock_id_d  = grant_id;
      end else if (lock_vld_q && !req_valid[lock_id_q]) begin
         lock_vld_d = 1'b0;
      end
`endif
   end

   // State registers; reset drops any in-flight tags so their responses never appear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q       <= '0;
         mem_we_q       <= 1'b0;
         mem_bank_sel_q <= '0;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         tag1_q         <= '0;
         tag2_q         <= '0;
`ifdef ARB_LOCK_EN
         lock_vld_q     <= 1'b0;
         lock_id_q      <= '0;
`endif
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         mem_we_q       <= mem_we_d;
         mem_bank_sel_q <= mem_bank_sel_d;
         mem_addr_q     <= mem_addr_d;
         mem_din_q      <= mem_din_d;
         tag1_q         <= tag1_d;
         tag2_q         <= tag2_d;
`ifdef ARB_LOCK_EN
         lock_vld_q     <= lock_vld_d;
         lock_id_q      <= lock_id_d;
`endif
      end
   end

   // Response routing: tag stage 2 lines up with the memory's registered read data.
   always_comb begin
      rsp_valid = '0;
      if (tag2_q.vld) rsp_valid[tag2_q.id] = 1'b1;
      rsp_data = (tag2_q.vld && !tag2_q.is_write) ? mem_dout : '0;
   end

   assign mem_we       = mem_we_q;
   assign mem_bank_sel = mem_bank_sel_q;
   assign mem_addr     = mem_addr_q;
   assign mem_din      = mem_din_q;

endmodule
